rx_frame_assembler: RTL and testbench

RX_FRAME_ASSEMBLER -- requirements
Module: rx_frame_assembler

---
 rtl/rx_frame_assembler.sv | 134 +++++++++++++
 tb/tb_rx_frame_assembler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_assembler.sv
// Serial receive frame assembler: start bit, DATA_BITS data bits LSB first, optional parity, stop bit.
// Optional even-parity check is built when the PARITY_CHECK_EN macro is defined.
module rx_frame_assembler #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sampleStrobe,
  input  logic                 dataIn,
  input  logic                 charAck,
  output logic [DATA_BITS-1:0] charOut,
  output logic                 charValid,
  output logic                 busy,
  output logic                 frameErr,
  output logic                 overrun,
`ifdef PARITY_CHECK_EN
  output logic                 parityErr,
`endif
  output logic [1:0]           o_dbg_state
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd3
  } state_t;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_cnt;
  logic [DATA_BITS-1:0] r_char;
  logic                 r_valid;
  logic                 r_ovr;
  logic                 r_ferr;
  logic                 w_last_bit;
  logic                 w_par_ok;
  logic                 w_stop_strobe;
  logic                 w_good_frame;
  logic                 w_bad_stop;

`ifdef PARITY_CHECK_EN
  logic r_par_bad;
  logic r_perr;
  assign w_par_ok  = !r_par_bad;
  assign parityErr = r_perr;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_last_bit    = (r_cnt == 4'(DATA_BITS - 1));
  assign w_stop_strobe = sampleStrobe && (r_state == S_STOP);
  assign w_good_frame  = w_stop_strobe && dataIn && w_par_ok;
  assign w_bad_stop    = w_stop_strobe && !dataIn;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (sampleStrobe) begin
      case (r_state)
        S_IDLE: if (!dataIn) w_next = S_DATA;
`ifdef PARITY_CHECK_EN
        S_DATA:   if (w_last_bit) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
`else
        S_DATA: if (w_last_bit) w_next = S_STOP;
`endif
        S_STOP:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_char  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_ferr <= w_bad_stop;
`ifdef PARITY_CHECK_EN
      r_perr <= w_stop_strobe && dataIn && r_par_bad;
      if (sampleStrobe && (r_state == S_PARITY)) r_par_bad <= ^{r_shift, dataIn};
`endif
      if (sampleStrobe && (r_state == S_IDLE) && !dataIn) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (sampleStrobe && (r_state == S_DATA)) begin
        r_shift <= {dataIn, r_shift[DATA_BITS-1:1]};
        r_cnt   <= r_cnt + 4'd1;
      end
      // An ack landing with a good frame lets the new character in but leaves overrun alone.
      if (w_good_frame) begin
        if (r_valid && !charAck) begin
          r_ovr <= 1'b1;
        end else begin
          r_char  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (charAck && r_valid) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign charOut     = r_char;
  assign charValid   = r_valid;
  assign overrun     = r_ovr;
  assign frameErr    = r_ferr;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Bench for rx_frame_assembler: directed table, hand-written corner sequences, and random frames
// checked against a frame-level reference model.
module tb_rx_frame_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       sampleStrobe;
  logic       dataIn;
  logic       charAck;
  logic [7:0] charOut;
  logic       charValid;
  logic       busy;
  logic       frameErr;
  logic       overrun;
  logic [1:0] dbg_state;
`ifdef PARITY_CHECK_EN
  logic       parityErr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_char;
  logic       m_valid;
  logic       m_ovr;

  always #5 clk = ~clk;

  rx_frame_assembler #(.DATA_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sampleStrobe (sampleStrobe),
    .dataIn       (dataIn),
    .charAck      (charAck),
    .charOut      (charOut),
    .charValid    (charValid),
    .busy         (busy),
    .frameErr     (frameErr),
    .overrun      (overrun),
`ifdef PARITY_CHECK_EN
    .parityErr    (parityErr),
`endif
    .o_dbg_state  (dbg_state)
  );

  typedef struct {
    logic       pre_ack;
    logic [7:0] data;
    logic       stop;
    logic       ack_stop;
    logic [7:0] e_char;
    logic       e_valid;
    logic       e_ovr;
    logic       e_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic strobe(input logic b);
    @(negedge clk);
    sampleStrobe = 1'b1;
    dataIn       = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sampleStrobe = 1'b0;
      dataIn       = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    sampleStrobe = 1'b0;
    charAck      = 1'b1;
    @(negedge clk);
    charAck      = 1'b0;
  endtask

  // Drives a whole frame; the stop strobe is left asserted for finish_frame to release.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_stop,
                            input int maxgap, input logic par_flip, input logic chk_busy);
    strobe(1'b0);
    if (chk_busy) begin
      idle(1);
      chk("busy_mid_frame", 32'(busy), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, maxgap));
      strobe(d[i]);
    end
`ifdef PARITY_CHECK_EN
    idle($urandom_range(0, maxgap));
    strobe((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip has no effect in this build");
`endif
    idle($urandom_range(0, maxgap));
    @(negedge clk);
    sampleStrobe = 1'b1;
    dataIn       = stop;
    charAck      = ack_stop;
  endtask

  task automatic finish_frame(input logic [7:0] e_char, input logic e_valid, input logic e_ovr,
                              input logic e_ferr, input logic e_perr);
    @(negedge clk);
    sampleStrobe = 1'b0;
    charAck      = 1'b0;
    chk("charOut", 32'(charOut), 32'(e_char));
    chk("charValid", 32'(charValid), 32'(e_valid));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    chk("frameErr", 32'(frameErr), 32'(e_ferr));
    chk("busy_after_stop", 32'(busy), 32'd0);
`ifdef PARITY_CHECK_EN
    chk("parityErr", 32'(parityErr), 32'(e_perr));
`else
    if (e_perr) $display("note: parity error expected in a build without parity");
`endif
    @(negedge clk);
    chk("frameErr_one_cycle", 32'(frameErr), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h52, 1'b1, 1'b0, 8'h52, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h52, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h52, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h7E, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};

    rst = 1'b0; sampleStrobe = 1'b0; dataIn = 1'b1; charAck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_charOut", 32'(charOut), 32'd0);
    chk("rst_charValid", 32'(charValid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frameErr", 32'(frameErr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_ack) do_ack();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_stop, 1, 1'b0, v == 0);
      finish_frame(vecs[v].e_char, vecs[v].e_valid, vecs[v].e_ovr, vecs[v].e_ferr, 1'b0);
    end

    // False start, then a real frame
    do_ack();
    strobe(1'b1);
    idle(1);
    chk("false_start_busy", 32'(busy), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    finish_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Framing error with nothing pending
    do_ack();
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    finish_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ferr_state_idle", 32'(dbg_state), 32'd0);

    // Overrun then ack
    send_frame(8'h11, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    finish_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    finish_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    do_ack();
    chk("ack_clears_valid", 32'(charValid), 32'd0);
    chk("ack_clears_overrun", 32'(overrun), 32'd0);

    // Reset mid-frame after 4 data bits
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'(i & 1));
    @(negedge clk);
    sampleStrobe = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frameErr", 32'(frameErr), 32'd0);
    rst = 1'b1;
    send_frame(8'h7E, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    finish_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_CHECK_EN
    do_ack();
    send_frame(8'h03, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    finish_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    finish_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    m_char = 8'h03;
`else
    m_char = 8'h7E;
`endif
    m_valid = 1'b1;
    m_ovr   = 1'b0;

    for (int k = 0; k < 200; k++) begin
      logic [7:0] d;
      logic       stop;
      logic       ack_stop;
      logic       pflip;
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 5) != 0);
      ack_stop = ($urandom_range(0, 3) == 0);
      pflip    = 1'b0;
`ifdef PARITY_CHECK_EN
      pflip    = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 3) == 0) begin
        do_ack();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) strobe(1'b1);
      send_frame(d, stop, ack_stop, 2, pflip, 1'b0);
      if (stop && !pflip) begin
        if (m_valid && !ack_stop) m_ovr = 1'b1;
        else begin
          m_char  = d;
          m_valid = 1'b1;
        end
      end else if (ack_stop && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      finish_frame(m_char, m_valid, m_ovr, !stop, stop && pflip);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
